// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: one bit per clock, LSB first, with a valid/ready
// operand port and a valid/ready result port. `SERIAL_SUB_ZERO_FLAG_EN adds a zero-result flag.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bo,
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    output logic             zero,
`endif
    output logic             busy
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] res_reg, res_next;
    logic [WIDTH-1:0] diff_reg, diff_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             br_reg, br_next;
    logic             bo_reg, bo_next;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    logic             zero_reg, zero_next;
`endif

    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;
    logic [WIDTH-1:0] res_shift;
    logic             bit_d;
    logic             bit_br;
    logic             last_bit;

    // One full-subtractor cell applied to the current LSBs.
    assign bit_d    = a_reg[0] ^ b_reg[0] ^ br_reg;
    assign bit_br   = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & br_reg);
    assign last_bit = (cnt_reg == CW'(WIDTH - 1));

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi = gi + 1) begin : g_shift
            assign a_shift[gi]   = a_reg[gi+1];
            assign b_shift[gi]   = b_reg[gi+1];
            assign res_shift[gi] = res_reg[gi+1];
        end
    endgenerate

    assign a_shift[WIDTH-1]   = 1'b0;
    assign b_shift[WIDTH-1]   = 1'b0;
    assign res_shift[WIDTH-1] = bit_d;

    // The result accumulates in res_reg; diff/bo are only updated when the
    // last bit lands, so the previous result stays visible while running.
    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        res_next   = res_reg;
        diff_next  = diff_reg;
        cnt_next   = cnt_reg;
        br_next    = br_reg;
        bo_next    = bo_reg;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        zero_next  = zero_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    a_next     = a;
                    b_next     = b;
                    res_next   = '0;
                    cnt_next   = '0;
                    br_next    = 1'b0;
                    state_next = RUN;
                end
            end
            RUN: begin
                a_next   = a_shift;
                b_next   = b_shift;
                res_next = res_shift;
                br_next  = bit_br;
                cnt_next = cnt_reg + CW'(1);
                if (last_bit) begin
                    diff_next  = res_shift;
                    bo_next    = bit_br;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
                    zero_next  = (res_shift == '0);
`endif
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            diff_reg  <= '0;
            cnt_reg   <= '0;
            br_reg    <= 1'b0;
            bo_reg    <= 1'b0;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
            zero_reg  <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            res_reg   <= res_next;
            diff_reg  <= diff_next;
            cnt_reg   <= cnt_next;
            br_reg    <= br_next;
            bo_reg    <= bo_next;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
            zero_reg  <= zero_next;
`endif
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg == RUN);
    assign out_valid = (state_reg == DONE);
    assign diff      = diff_reg;
    assign bo        = bo_reg;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    assign zero      = zero_reg;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Randomized and directed bench for serial_sub_ctrl (WIDTH=8) against an
// arithmetic reference model of modular subtraction.
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       out_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] diff;
    logic       bo;
    logic       busy;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    logic       zero;
`endif

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bo        (bo),
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        .zero      (zero),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    int         lat;
    logic       run_ok;
    logic [7:0] got_diff;
    logic       got_bo;

    function automatic logic [7:0] ref_diff(input logic [7:0] x, input logic [7:0] y);
        int t;
        t = int'(x) - int'(y);
        if (t < 0) t = t + 256;
        return 8'(t);
    endfunction

    function automatic logic ref_bo(input logic [7:0] x, input logic [7:0] y);
        return (x < y);
    endfunction

    // Called at a negedge in IDLE; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [7:0] ta, input logic [7:0] tb_v);
        a        = ta;
        b        = tb_v;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
    endtask

    // Counts edges until out_valid, noting whether RUN-phase outputs stayed
    // as required; operand inputs are scrambled throughout.
    task automatic wait_result();
        logic [7:0] prev_diff;
        logic       prev_bo;
        prev_diff = diff;
        prev_bo   = bo;
        run_ok    = (busy === 1'b1) && (in_ready === 1'b0) && (out_valid === 1'b0);
        lat       = 0;
        while (lat < 40) begin
            in_valid = 1'($urandom);
            a        = 8'($urandom);
            b        = 8'($urandom);
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (out_valid === 1'b1) break;
            if (busy !== 1'b1 || in_ready !== 1'b0 || diff !== prev_diff || bo !== prev_bo)
                run_ok = 1'b0;
        end
        in_valid = 1'b0;
        got_diff = diff;
        got_bo   = bo;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        a         = 8'h12;
        b         = 8'h34;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests++;
        if (diff !== 8'h00) begin fails++; $display("FAIL reset_diff got=%h exp=00", diff); end
        tests++;
        if (bo !== 1'b0) begin fails++; $display("FAIL reset_bo got=%b exp=0", bo); end
        rst      = 1'b0;
        in_valid = 1'b0;
        $display("[TB] reset done");
    endtask

    task automatic test_directed();
        logic [7:0] ta [4] = '{8'h05, 8'h03, 8'h00, 8'hA5};
        logic [7:0] tb_v [4] = '{8'h03, 8'h05, 8'hFF, 8'hA5};
        logic [7:0] exp_d [4] = '{8'h02, 8'hFE, 8'h01, 8'h00};
        logic       exp_b [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            out_ready = 1'b1;
            start_op(ta[i], tb_v[i]);
            wait_result();
            $display("[TB] directed a=%h b=%h diff=%h bo=%b lat=%0d", ta[i], tb_v[i], got_diff, got_bo, lat);
            tests++;
            if (lat != 8) begin fails++; $display("FAIL dir_latency got=%0d exp=8", lat); end
            tests++;
            if (got_diff !== exp_d[i]) begin fails++; $display("FAIL dir_diff got=%h exp=%h", got_diff, exp_d[i]); end
            tests++;
            if (got_bo !== exp_b[i]) begin fails++; $display("FAIL dir_bo got=%b exp=%b", got_bo, exp_b[i]); end
            tests++;
            if (run_ok !== 1'b1) begin fails++; $display("FAIL dir_run_flags got=%b exp=1", run_ok); end
`ifdef SERIAL_SUB_ZERO_FLAG_EN
            tests++;
            if (zero !== (exp_d[i] == 8'h00)) begin fails++; $display("FAIL dir_zero got=%b exp=%b", zero, exp_d[i] == 8'h00); end
`endif
            @(posedge clk);
            @(negedge clk);
            tests++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                fails++; $display("FAIL dir_return_idle got=%b%b exp=10", in_ready, out_valid);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        start_op(8'h3C, 8'h5A);
        wait_result();
        $display("[TB] backpressure a=3c b=5a diff=%h bo=%b lat=%0d", got_diff, got_bo, lat);
        tests++;
        if (got_diff !== 8'hE2 || got_bo !== 1'b1) begin
            fails++; $display("FAIL bp_result got=%h/%b exp=e2/1", got_diff, got_bo);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a        = 8'($urandom);
            b        = 8'($urandom);
            @(posedge clk);
            @(negedge clk);
            tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== 8'hE2 || bo !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold got=v%b r%b %h/%b exp=v1 r0 e2/1", out_valid, in_ready, diff, bo);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++; $display("FAIL bp_release got=%b%b exp=10", in_ready, out_valid);
        end
        tests++;
        if (diff !== 8'hE2) begin fails++; $display("FAIL bp_idle_hold got=%h exp=e2", diff); end
    endtask

    task automatic test_reset_mid_run();
        out_ready = 1'b1;
        start_op(8'h77, 8'h11);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL mid_rst_flags got=r%b v%b b%b exp=r1 v0 b0", in_ready, out_valid, busy);
        end
        tests++;
        if (diff !== 8'h00 || bo !== 1'b0) begin
            fails++; $display("FAIL mid_rst_result got=%h/%b exp=00/0", diff, bo);
        end
        start_op(8'h10, 8'h01);
        wait_result();
        $display("[TB] after reset a=10 b=01 diff=%h bo=%b lat=%0d", got_diff, got_bo, lat);
        tests++;
        if (got_diff !== 8'h0F || got_bo !== 1'b0 || lat != 8) begin
            fails++; $display("FAIL mid_rst_next got=%h/%b lat %0d exp=0f/0 lat 8", got_diff, got_bo, lat);
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] a1, b1, a2, b2;
        a1 = 8'($urandom); b1 = 8'($urandom);
        a2 = 8'($urandom); b2 = 8'($urandom);
        out_ready = 1'b1;
        start_op(a1, b1);
        wait_result();
        $display("[TB] b2b#1 a=%h b=%h diff=%h bo=%b lat=%0d", a1, b1, got_diff, got_bo, lat);
        tests++;
        if (got_diff !== ref_diff(a1, b1) || got_bo !== ref_bo(a1, b1)) begin
            fails++; $display("FAIL b2b_first got=%h/%b exp=%h/%b", got_diff, got_bo, ref_diff(a1, b1), ref_bo(a1, b1));
        end
        in_valid = 1'b1;
        a        = a2;
        b        = b2;
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL b2b_no_overlap got=r%b b%b exp=r1 b0", in_ready, busy);
        end
        start_op(a2, b2);
        wait_result();
        $display("[TB] b2b#2 a=%h b=%h diff=%h bo=%b lat=%0d", a2, b2, got_diff, got_bo, lat);
        tests++;
        if (got_diff !== ref_diff(a2, b2) || got_bo !== ref_bo(a2, b2) || lat != 8) begin
            fails++; $display("FAIL b2b_second got=%h/%b lat %0d exp=%h/%b lat 8", got_diff, got_bo, lat, ref_diff(a2, b2), ref_bo(a2, b2));
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] ta, tb_v;
        int         stall;
        for (int i = 0; i < 30; i++) begin
            ta = 8'($urandom);
            tb_v = (i % 7 == 0) ? ta : 8'($urandom);
            out_ready = 1'b0;
            start_op(ta, tb_v);
            wait_result();
            $display("[TB] random a=%h b=%h diff=%h bo=%b lat=%0d", ta, tb_v, got_diff, got_bo, lat);
            tests++;
            if (got_diff !== ref_diff(ta, tb_v) || got_bo !== ref_bo(ta, tb_v)) begin
                fails++; $display("FAIL rnd_result got=%h/%b exp=%h/%b", got_diff, got_bo, ref_diff(ta, tb_v), ref_bo(ta, tb_v));
            end
            tests++;
            if (lat != 8 || run_ok !== 1'b1) begin
                fails++; $display("FAIL rnd_timing got=lat %0d run %b exp=lat 8 run 1", lat, run_ok);
            end
`ifdef SERIAL_SUB_ZERO_FLAG_EN
            tests++;
            if (zero !== (ref_diff(ta, tb_v) == 8'h00)) begin
                fails++; $display("FAIL rnd_zero got=%b exp=%b", zero, ref_diff(ta, tb_v) == 8'h00);
            end
`endif
            stall = $urandom_range(0, 3);
            for (int k = 0; k < stall; k++) begin
                @(posedge clk);
                @(negedge clk);
            end
            tests++;
            if (out_valid !== 1'b1 || diff !== ref_diff(ta, tb_v)) begin
                fails++; $display("FAIL rnd_stall got=v%b %h exp=v1 %h", out_valid, diff, ref_diff(ta, tb_v));
            end
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            tests++;
            if (in_ready !== 1'b1) begin fails++; $display("FAIL rnd_handshake got=%b exp=1", in_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  operand pair a/b valid.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  WIDTH  minuend.
REQ-007 b  input  WIDTH  subtrahend.
REQ-008 out_valid  output  1  diff/bo hold a completed result.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 diff  output  WIDTH  difference, a-b modulo 2^WIDTH.
REQ-011 bo  output  1  final borrow; 1 iff a<b unsigned.
REQ-012 busy  output  1  serial subtraction in progress.

Function
REQ-013 FSM states SHALL be IDLE, RUN, DONE; encoding is free.
REQ-014 IDLE: in_ready=1, busy=0, out_valid=0; in_valid=1 at an edge captures a and b into shift registers, clears bit counter and borrow register, and moves to RUN.
REQ-015 RUN: in_ready=0, busy=1; each edge processes one bit, LSB first: d=a0^b0^br, br_next=(~a0&b0)|(~(a0^b0)&br); d shifts into diff MSB; operand registers shift right.
REQ-016 After the WIDTH-th RUN edge the state SHALL be DONE; out_valid rises exactly WIDTH edges after the accepting edge.
REQ-017 DONE: out_valid=1, in_ready=0, busy=0; diff and bo stay stable until out_valid&out_ready at an edge, which returns the FSM to IDLE.
REQ-018 No overlap: a new operand pair is accepted no earlier than the edge after the result handshake; in_valid outside IDLE is ignored.
REQ-019 a and b SHALL be sampled only at the accepting edge; later input changes do not affect the result.
REQ-020 out_ready outside DONE has no effect.
REQ-021 diff and bo registers SHALL be held (not cleared) in IDLE and RUN; only out_valid qualifies them.

Reset
REQ-022 rst=1 at an edge SHALL force IDLE, out_valid=0, busy=0, in_ready=1, diff=0, bo=0, counter=0, borrow=0, from any state including mid-RUN and DONE (result discarded).
REQ-023 rst has priority over in_valid and out_ready in the same cycle.

Configuration
REQ-024 Macro SERIAL_SUB_ZERO_FLAG_EN defined: extra output zero (1 bit, after bo in the port list), registered, valid with out_valid, 1 iff diff==0, reset 0.
REQ-025 Macro undefined: no zero port and no associated logic; all other behaviour identical.

Verification (WIDTH=8)
REQ-026 a=5, b=3, out_ready=1 -> out_valid exactly 8 edges after accept, diff=8'h02, bo=0, return to IDLE next edge.
REQ-027 a=3, b=5 -> diff=8'hFE, bo=1; a=8'h00, b=8'hFF -> diff=8'h01, bo=1.
REQ-028 a=b=8'hA5 -> diff=8'h00, bo=0, zero=1 when SERIAL_SUB_ZERO_FLAG_EN defined.
REQ-029 out_ready held 0 for 5 cycles in DONE while in_valid=1 with new operands -> diff/bo/out_valid stable, in_ready=0, new operands not taken; after handshake in_ready=1.
REQ-030 rst pulsed on 3rd RUN cycle -> next cycle IDLE, in_ready=1, out_valid=0, diff=0, bo=0; following op a=8'h10, b=8'h01 -> diff=8'h0F, bo=0.
